// File: rtl/sparse_expand.sv
// Sparse-to-dense expander: scatters up to NNZ packed values into LENGTH lanes, CHUNK mask bits per cycle.
// Optional overflow flag is enabled by defining SPARSE_EXPAND_OVF_EN.
module sparse_expand #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int LENGTH = 32,
  parameter int NNZ    = 16,
  parameter int CHUNK  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [IL+FL-1:0]           i_im [NNZ],
  input  logic        [LENGTH-1:0]          i_mask,
  input  logic                              input_ready,
  input  logic                              output_taken,
  output logic signed [IL+FL-1:0]           o_dense [LENGTH],
  output logic        [LENGTH-1:0]          o_mask,
  output logic        [$clog2(LENGTH+1)-1:0] o_nnz,
  output logic                              o_ovf,
  output logic                              o_valid,
  output logic        [1:0]                 state
);

  localparam int W   = IL + FL;
  localparam int NCH = LENGTH / CHUNK;
  localparam int NW  = $clog2(LENGTH + 1);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW  = (NNZ > 1) ? $clog2(NNZ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EXPAND = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t              r_state;
  logic signed [W-1:0] r_im    [NNZ];
  logic signed [W-1:0] r_dense [LENGTH];
  logic [LENGTH-1:0]   r_mask;
  logic [CW-1:0]       r_chunk;
  logic [NW-1:0]       r_ptr;
  logic [NW-1:0]       r_nnz;
  logic                r_valid;

  logic [CHUNK-1:0]    w_bits;
  logic signed [W-1:0] w_val [CHUNK];
  logic [NW-1:0]       w_cnt;
  logic [NW-1:0]       w_nnz_nxt;
  logic                w_last;

  // Slot rank of each set lane is ptr plus the set bits below it in this chunk.
  always_comb begin
    w_bits = '0;
    for (int k = 0; k < LENGTH; k++) begin
      if (CW'(k / CHUNK) == r_chunk) w_bits[k % CHUNK] = r_mask[k];
    end
    w_cnt = r_ptr;
    for (int j = 0; j < CHUNK; j++) begin
      w_val[j] = '0;
      if (w_bits[j]) begin
        if (w_cnt < NW'(NNZ)) w_val[j] = r_im[w_cnt[IW-1:0]];
        w_cnt = w_cnt + NW'(1);
      end
    end
  end

  assign w_nnz_nxt = r_nnz + (w_cnt - r_ptr);
  assign w_last    = (r_chunk == CW'(NCH - 1));

  always_ff @(posedge clk) begin
    if (r_state == IDLE && input_ready) r_im <= i_im;
  end

`ifdef SPARSE_EXPAND_OVF_EN
  logic r_ovf;
  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_chunk <= '0;
      r_ptr   <= '0;
      r_nnz   <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < LENGTH; k++) r_dense[k] <= '0;
`ifdef SPARSE_EXPAND_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (input_ready) begin
            r_state <= EXPAND;
            r_mask  <= i_mask;
            r_chunk <= '0;
            r_ptr   <= '0;
            r_nnz   <= '0;
            for (int k = 0; k < LENGTH; k++) r_dense[k] <= '0;
`ifdef SPARSE_EXPAND_OVF_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        EXPAND: begin
          for (int k = 0; k < LENGTH; k++) begin
            if (CW'(k / CHUNK) == r_chunk) r_dense[k] <= w_val[k % CHUNK];
          end
          r_ptr <= w_cnt;
          r_nnz <= w_nnz_nxt;
          if (w_last) begin
            r_state <= DONE;
            r_valid <= 1'b1;
`ifdef SPARSE_EXPAND_OVF_EN
            r_ovf   <= (w_nnz_nxt > NW'(NNZ));
`endif
          end else begin
            r_chunk <= r_chunk + CW'(1);
          end
        end
        DONE: begin
          if (output_taken) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_dense = r_dense;
  assign o_mask  = r_mask;
  assign o_nnz   = r_nnz;
  assign o_valid = r_valid;
  assign state   = r_state;

endmodule

// File: tb/tb_sparse_expand.sv
// Self-checking bench for sparse_expand: vector table, random masks against a rank-based model, handshake corners.
module tb_sparse_expand;
  localparam int L = 32;
  localparam int N = 16;
  localparam int W = 20;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [W-1:0] im [N];
  logic [L-1:0]        mask;
  logic                ready;
  logic                taken;
  logic signed [W-1:0] dense [L];
  logic [L-1:0]        o_mask;
  logic [5:0]          nnz;
  logic                ovf;
  logic                valid;
  logic [1:0]          state;

  sparse_expand dut (
    .clk(clk), .reset(reset), .i_im(im), .i_mask(mask),
    .input_ready(ready), .output_taken(taken),
    .o_dense(dense), .o_mask(o_mask), .o_nnz(nnz), .o_ovf(ovf),
    .o_valid(valid), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic signed [W-1:0] exp_dense [L];
  int   exp_nnz;
  logic exp_ovf;

  typedef struct {
    logic [31:0] mask;
    int          nnz;
    logic        ovf_if_en;
    int          lane;
    int          lane_val;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: the r-th set bit (counting from lane 0) receives value r, if a slot exists.
  task automatic model;
    int r;
    r = 0;
    for (int k = 0; k < L; k++) begin
      exp_dense[k] = '0;
      if (mask[k]) begin
        if (r < N) exp_dense[k] = im[r];
        r++;
      end
    end
    exp_nnz = r;
`ifdef SPARSE_EXPAND_OVF_EN
    exp_ovf = (r > N);
`else
    exp_ovf = 1'b0;
`endif
  endtask

  task automatic chk_dense(input string nm);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int k = 0; k < L; k++) begin
      if (dense[k] !== exp_dense[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d lanes differ, lane %0d got %0d expected %0d",
               nm, bad, first, dense[first], exp_dense[first]);
    end
  endtask

  task automatic run_vec(input string nm);
    int cyc;
    model();
    ready = 1'b1;
    tick();
    chk({nm, " accept state"}, state, 1);
    ready = 1'b0;
    cyc = 0;
    while (!valid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk({nm, " latency"}, cyc, 4);
    chk({nm, " state"}, state, 2);
    chk_dense({nm, " dense"});
    chk({nm, " nnz"}, nnz, exp_nnz);
    chk({nm, " ovf"}, ovf, exp_ovf);
    chk({nm, " mask"}, o_mask, mask);
  endtask

  task automatic release_out(input string nm);
    taken = 1'b1;
    tick();
    taken = 1'b0;
    chk({nm, " idle state"}, state, 0);
    chk({nm, " valid drop"}, valid, 0);
  endtask

  task automatic seq_im;
    for (int j = 0; j < N; j++) im[j] = W'(j + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h000000FF, 8,  1'b0, 7,  8};
    tbl[1] = '{32'h49D5B4DB, 18, 1'b1, 24, 16};
    tbl[2] = '{32'h49D5B4DB, 18, 1'b1, 27, 0};
    tbl[3] = '{32'h00000000, 0,  1'b0, 5,  0};
    tbl[4] = '{32'hFFFFFFFF, 32, 1'b1, 15, 16};
    tbl[5] = '{32'h80000001, 2,  1'b0, 31, 2};

    reset = 1'b1;
    ready = 1'b0;
    taken = 1'b0;
    mask  = '0;
    for (int j = 0; j < N; j++) im[j] = '0;
    tick();
    tick();
    for (int k = 0; k < L; k++) exp_dense[k] = '0;
    chk("reset state", state, 0);
    chk("reset valid", valid, 0);
    chk("reset nnz", nnz, 0);
    chk("reset mask", o_mask, 0);
    chk("reset ovf", ovf, 0);
    chk_dense("reset dense");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      logic eo;
      mask = tbl[i].mask;
      seq_im();
      run_vec($sformatf("vec%0d", i));
`ifdef SPARSE_EXPAND_OVF_EN
      eo = tbl[i].ovf_if_en;
`else
      eo = 1'b0;
`endif
      chk($sformatf("vec%0d table nnz", i), nnz, tbl[i].nnz);
      chk($sformatf("vec%0d table ovf", i), ovf, eo);
      chk($sformatf("vec%0d lane%0d", i, tbl[i].lane), dense[tbl[i].lane], tbl[i].lane_val);
      release_out($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       mask = $urandom;
        1:       mask = $urandom & $urandom;
        default: mask = $urandom | $urandom;
      endcase
      for (int j = 0; j < N; j++) im[j] = W'($urandom);
      run_vec($sformatf("rnd%0d", i));
      release_out($sformatf("rnd%0d", i));
    end

    mask = 32'h0000F00F;
    seq_im();
    run_vec("hs");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hs hold valid %0d", i), valid, 1);
      chk_dense($sformatf("hs hold dense %0d", i));
    end
    taken = 1'b1;
    ready = 1'b1;
    tick();
    taken = 1'b0;
    chk("hs taken+ready state", state, 0);
    chk("hs taken+ready valid", valid, 0);
    chk_dense("hs dense kept");
    tick();
    chk("hs next accept", state, 1);
    ready = 1'b0;
    repeat (4) tick();
    chk("hs second done", state, 2);
    chk_dense("hs second dense");
    release_out("hs");

    mask = 32'h000000FF;
    seq_im();
    model();
    ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold ready expand %0d", i), state, 1);
    end
    tick();
    chk("hold ready done", state, 2);
    tick();
    chk("hold ready stays done", state, 2);
    ready = 1'b0;
    chk("hold ready nnz", nnz, 8);
    chk_dense("hold ready dense");
    release_out("hold ready");
    taken = 1'b1;
    tick();
    taken = 1'b0;
    chk("taken in idle", state, 0);

    mask = 32'h000000FF;
    seq_im();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    tick();
    chk("mid partial lane0", dense[0], 1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < L; k++) exp_dense[k] = '0;
    chk("mid reset state", state, 0);
    chk("mid reset valid", valid, 0);
    chk("mid reset nnz", nnz, 0);
    chk("mid reset mask", o_mask, 0);
    chk("mid reset ovf", ovf, 0);
    chk_dense("mid reset dense");
    tick();
    reset = 1'b0;
    tick();
    mask = 32'hA5A5A5A5;
    run_vec("post reset");
    release_out("post reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
